// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch stage: PC/OldPC/IR with a req/ready memory handshake.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned fetch targets raise misalign instead of issuing a read.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_INC   = 32'd4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_start,
   input  logic        pc_load,
   input  logic [31:0] pc_next,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [31:0] instr,
   output logic [24:0] imm_fields,
   output logic [31:0] pc,
   output logic [31:0] old_pc,
   output logic        instr_valid,
   output logic        busy,
   output logic        misalign
);

   typedef enum logic {IDLE, REQ} state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] old_pc_q, old_pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic        pend_valid_q, pend_valid_d;
   logic        mem_req_q, mem_req_d;
   logic        busy_q, busy_d;
   logic        instr_valid_q, instr_valid_d;
   logic        misalign_d;
   logic [31:0] target;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         old_pc_q      <= RESET_PC;
         instr_q       <= NOP;
         mem_addr_q    <= RESET_PC;
         pend_pc_q     <= RESET_PC;
         pend_valid_q  <= 1'b0;
         mem_req_q     <= 1'b0;
         busy_q        <= 1'b0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         old_pc_q      <= old_pc_d;
         instr_q       <= instr_d;
         mem_addr_q    <= mem_addr_d;
         pend_pc_q     <= pend_pc_d;
         pend_valid_q  <= pend_valid_d;
         mem_req_q     <= mem_req_d;
         busy_q        <= busy_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      old_pc_d      = old_pc_q;
      instr_d       = instr_q;
      mem_addr_d    = mem_addr_q;
      pend_pc_d     = pend_pc_q;
      pend_valid_d  = pend_valid_q;
      mem_req_d     = mem_req_q;
      busy_d        = busy_q;
      instr_valid_d = 1'b0;
      misalign_d    = 1'b0;
      target        = pc_load ? pc_next : pc_q;
      unique case (state_q)
         IDLE: begin
            if (fetch_start) begin
               pc_d = target;
`ifdef FETCH_MISALIGN_TRAP_EN
               if (target[1:0] != 2'b00) begin
                  misalign_d = 1'b1;
               end else begin
                  mem_addr_d = target;
                  mem_req_d  = 1'b1;
                  busy_d     = 1'b1;
                  state_d    = REQ;
               end
`else
               // Memory always sees a word address; pc keeps the unaligned value.
               mem_addr_d = target & ~32'h3;
               mem_req_d  = 1'b1;
               busy_d     = 1'b1;
               state_d    = REQ;
`endif
            end else if (pc_load) begin
               pc_d = pc_next;
            end
         end
         REQ: begin
            if (mem_ready) begin
               instr_d       = mem_rdata;
               old_pc_d      = pc_q;
               // A same-cycle redirect beats any earlier pending one, which beats PC+4.
               pc_d          = pc_load ? pc_next : (pend_valid_q ? pend_pc_q : pc_q + PC_INC);
               mem_req_d     = 1'b0;
               busy_d        = 1'b0;
               instr_valid_d = 1'b1;
               pend_valid_d  = 1'b0;
               state_d       = IDLE;
            end else if (pc_load) begin
               pend_pc_d    = pc_next;
               pend_valid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misalign_q;
   always_ff @(posedge clk) begin
      if (reset) misalign_q <= 1'b0;
      else       misalign_q <= misalign_d;
   end
   assign misalign = misalign_q;
`else
   assign misalign = 1'b0;
`endif

   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_addr_q;
   assign instr       = instr_q;
   assign imm_fields  = instr_q[31:7];
   assign pc          = pc_q;
   assign old_pc      = old_pc_q;
   assign instr_valid = instr_valid_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_start;
   logic        pc_load;
   logic [31:0] pc_next;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [31:0] instr;
   logic [24:0] imm_fields;
   logic [31:0] pc;
   logic [31:0] old_pc;
   logic        instr_valid;
   logic        busy;
   logic        misalign;

   int checks = 0;
   int errors = 0;

   // Reference model: an outstanding-fetch flag, a redirect queue and the architectural registers.
   logic [31:0] m_pc, m_old, m_instr, m_addr;
   bit          m_out, m_iv, m_mis;
   logic [31:0] redir_q[$];
   int          valid_pulses;

   instr_fetch_unit dut (
      .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc_load(pc_load),
      .pc_next(pc_next), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .instr(instr), .imm_fields(imm_fields), .pc(pc),
      .old_pc(old_pc), .instr_valid(instr_valid), .busy(busy), .misalign(misalign)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic modelStep(input bit rst, input bit fs, input bit pl, input logic [31:0] pn,
                            input bit rdy, input logic [31:0] rd);
      logic [31:0] tgt;
      if (rst) begin
         m_pc = 32'h0; m_old = 32'h0; m_instr = 32'h13; m_addr = 32'h0;
         m_out = 0; m_iv = 0; m_mis = 0;
         redir_q.delete();
         return;
      end
      m_iv = 0;
      m_mis = 0;
      if (!m_out) begin
         if (fs) begin
            tgt = pl ? pn : m_pc;
            m_pc = tgt;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (tgt % 4 != 0) m_mis = 1;
            else begin m_addr = tgt; m_out = 1; end
`else
            m_addr = tgt - (tgt % 4);
            m_out = 1;
`endif
         end else if (pl) m_pc = pn;
      end else if (rdy) begin
         m_instr = rd;
         m_old = m_pc;
         if (pl) m_pc = pn;
         else if (redir_q.size() > 0) m_pc = redir_q[$];
         else m_pc = m_pc + 4;
         m_out = 0;
         m_iv = 1;
         redir_q.delete();
      end else if (pl) redir_q.push_back(pn);
   endtask

   task automatic compareAll(input string tag);
      checkOutput({tag, "_pc"}, pc, m_pc);
      checkOutput({tag, "_old_pc"}, old_pc, m_old);
      checkOutput({tag, "_instr"}, instr, m_instr);
      checkOutput({tag, "_imm"}, {7'd0, imm_fields}, {7'd0, m_instr[31:7]});
      checkOutput({tag, "_req"}, {31'd0, mem_req}, {31'd0, m_out});
      checkOutput({tag, "_busy"}, {31'd0, busy}, {31'd0, m_out});
      checkOutput({tag, "_iv"}, {31'd0, instr_valid}, {31'd0, m_iv});
      checkOutput({tag, "_mis"}, {31'd0, misalign}, {31'd0, m_mis});
      if (m_out) checkOutput({tag, "_addr"}, mem_addr, m_addr);
   endtask

   // Drive one cycle of inputs, advance the model at the edge and compare just after it.
   task automatic applyStimulus(input string tag, input bit rst, input bit fs, input bit pl,
                                input logic [31:0] pn, input bit rdy, input logic [31:0] rd);
      reset = rst; fetch_start = fs; pc_load = pl; pc_next = pn; mem_ready = rdy; mem_rdata = rd;
      @(posedge clk);
      modelStep(rst, fs, pl, pn, rdy, rd);
      #1;
      if (instr_valid) valid_pulses++;
      compareAll(tag);
   endtask

   initial begin
      reset = 1; fetch_start = 0; pc_load = 0; pc_next = 0; mem_ready = 0; mem_rdata = 0;
      valid_pulses = 0;
      modelStep(1, 0, 0, 0, 0, 0);

      // Test 1: minimum two-cycle fetch
      applyStimulus("t1_rst", 1, 0, 0, 0, 0, 0);
      applyStimulus("t1_rst", 1, 0, 0, 0, 1, 32'hDEAD_BEEF);
      checkOutput("t1_reset_instr", instr, 32'h0000_0013);
      applyStimulus("t1_issue", 0, 1, 0, 0, 0, 0);
      checkOutput("t1_addr", mem_addr, 32'h0);
      applyStimulus("t1_hs", 0, 0, 0, 0, 1, 32'h0050_0093);
      checkOutput("t1_instr", instr, 32'h0050_0093);
      checkOutput("t1_imm", {7'd0, imm_fields}, 32'h0000_A001);
      checkOutput("t1_pc", pc, 32'h4);
      applyStimulus("t1_idle", 0, 0, 0, 0, 0, 0);
      applyStimulus("t1_idle", 0, 0, 0, 0, 0, 0);
      checkOutput("t1_pulses", valid_pulses, 1);

      // Test 2: three wait cycles, second fetch_start ignored
      applyStimulus("t2_issue", 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus("t2_wait", 0, 1, 0, 0, 0, 0);
         checkOutput("t2_addr_hold", mem_addr, 32'h4);
         checkOutput("t2_busy", {31'd0, busy}, 32'd1);
      end
      applyStimulus("t2_hs", 0, 1, 0, 0, 1, 32'h1111_2222);
      checkOutput("t2_pc", pc, 32'h8);

      // Test 3: redirect during REQ, then simultaneous redirect and fetch in IDLE
      applyStimulus("t3_issue", 0, 1, 0, 0, 0, 0);
      applyStimulus("t3_redir", 0, 0, 1, 32'h100, 0, 0);
      applyStimulus("t3_hs", 0, 0, 0, 0, 1, 32'h3333_4444);
      checkOutput("t3_pc", pc, 32'h100);
      applyStimulus("t3_both", 0, 1, 1, 32'h200, 0, 0);
      checkOutput("t3_addr", mem_addr, 32'h200);
      applyStimulus("t3_hs2", 0, 0, 0, 0, 1, 32'h5555_6666);

      // Test 4: PC wrap
      applyStimulus("t4_load", 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
      applyStimulus("t4_issue", 0, 1, 0, 0, 0, 0);
      applyStimulus("t4_hs", 0, 0, 0, 0, 1, 32'h0000_0013);
      checkOutput("t4_pc", pc, 32'h0);
      checkOutput("t4_old", old_pc, 32'hFFFF_FFFC);

      // Test 5: reset mid-fetch, stale ready afterwards
      applyStimulus("t5_issue", 0, 1, 0, 0, 0, 0);
      applyStimulus("t5_redir", 0, 0, 1, 32'h40, 0, 0);
      applyStimulus("t5_rst", 1, 0, 0, 0, 0, 0);
      applyStimulus("t5_stale", 0, 0, 0, 0, 1, 32'hCAFE_F00D);
      checkOutput("t5_instr", instr, 32'h0000_0013);
      checkOutput("t5_pc", pc, 32'h0);

      // Test 6: misaligned target
      applyStimulus("t6_load", 0, 0, 1, 32'h102, 0, 0);
      applyStimulus("t6_issue", 0, 1, 0, 0, 0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
      checkOutput("t6_mis", {31'd0, misalign}, 32'd1);
      checkOutput("t6_req", {31'd0, mem_req}, 32'd0);
`else
      checkOutput("t6_addr", mem_addr, 32'h100);
      checkOutput("t6_mis", {31'd0, misalign}, 32'd0);
`endif
      checkOutput("t6_pc", pc, 32'h102);
      applyStimulus("t6_hs", 0, 0, 0, 0, 1, 32'h7777_8888);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic [31:0] pn;
         pn = $urandom;
         if ($urandom_range(0, 3) != 0) pn[1:0] = 2'b00;
         applyStimulus("rnd", ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0),
                       ($urandom_range(0, 4) == 0), pn, ($urandom_range(0, 2) == 0), $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
